mc_mem_responder: RTL and testbench
===================================

// Module: mc_mem_responder
// PURPOSE
//  Memory-side responder for the multi-cycle CPU's unified inst/data port.
//  - Serves the controller's MemRead/MemWrite requests with configurable wait states; ready handshake.
//  - Sits between the controller/datapath address mux (PC or ALUOut) and the word RAM.
//  - Lets the CPU FSM stall on slow memory instead of assuming single-cycle access.
// PARAMETERS
//  DEPTH_WORDS  256  RAM depth in 32-bit words; power of two.
//  RD_LATENCY   2    Cycles from the request-accept edge to ready for reads; must be >= 1.
//  WR_LATENCY   1    Cycles from the request-accept edge to ready for writes; must be >= 1.
// PORTS
//  clk        in   1   clock, rising edge.
//  reset      in   1   asynchronous, active-high.
//  mem_read   in   1   read request; held by the requester until ready.
//  mem_write  in   1   write request; held by the requester until ready.
//  addr       in   32  byte address; addr[1:0] ignored.
//  wdata      in   32  write data, sampled at the accept edge.
//  rdata      out  32  read data; valid while ready=1, then held until the next read completes.
//  ready      out  1   one-cycle completion pulse.
//  busy       out  1   high from the cycle after the accept edge until ready drops.
//  err        out  1   range-error pulse coincident with ready; driven 0 without MEM_RANGE_CHECK_EN.
// BEHAVIOUR
//  Reset state: IDLE; ready=0, busy=0, err=0, rdata=0; RAM contents are not cleared.
//  States: IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: at an edge with mem_read|mem_write=1, latch op, word index and wdata; go to BUSY.
//    - Load cnt = LAT-1, where LAT = RD_LATENCY or WR_LATENCY.
//  - BUSY: busy=1. Each edge with cnt!=0 decrements cnt.
//    - At the edge with cnt==0: go to RESP. A read loads rdata from RAM; a write commits to RAM.
//  - RESP: ready=1 and busy=1 for exactly one cycle; next edge returns to IDLE unconditionally.
//  - Requests are sampled only in IDLE. A request still high in the RESP cycle is accepted at the first IDLE edge.
//  - Throughput: one access per LAT+2 cycles.
//  - ready is asserted LAT cycles after the accept edge.
//  Simultaneous mem_read & mem_write in IDLE: treated as a write using WR_LATENCY; rdata is unchanged.
//  Input changes during BUSY/RESP are ignored because addr, wdata and op are latched.
//  Word index = addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so accesses wrap modulo DEPTH.
//  Read-after-write to the same word returns the new data, since the write commits before RESP.
//  Reset mid-operation returns immediately to IDLE.
//  - A write not yet committed is discarded.
//  - A committed write is retained.
//  - No ready pulse is produced.
// CONFIGURATION
//  MEM_RANGE_CHECK_EN defined:
//  - If any addr bit above the index field is nonzero, err=1 with ready.
//  - An out-of-range write is suppressed.
//  - An out-of-range read returns MEM_ERR_WORD (32'hDEAD_BEEF).
//  MEM_RANGE_CHECK_EN undefined: the address wraps silently and err is tied to 0.
// STRUCTURE
//  Package mc_mem_pkg holds:
//  - the state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
//  - MEM_ERR_WORD;
//  - the localparam IDX_W = $clog2(DEPTH_WORDS).
//  Sub-module mc_mem_array: DEPTH_WORDS x 32 RAM with synchronous write and registered read, enabled by the FSM.
//  The top level holds the FSM, latency counter and request latches.
// TESTING
//  - Reset, then mem_write addr=0x10 wdata=0xCAFEF00D, WR_LATENCY=1 -> ready 1 cycle after accept, err=0, busy drops after.
//  - mem_read addr=0x10, RD_LATENCY=2 -> ready 2 cycles after accept, rdata=0xCAFEF00D; rdata holds after ready falls.
//  - mem_read & mem_write together, addr=0x20 wdata=0x1234 -> write performed, WR_LATENCY timing; a following read of 0x20 returns 0x1234.
//  - Change addr/wdata while busy -> the latched values are used; no second access until IDLE.
//  - Assert reset 1 cycle after a write accept with WR_LATENCY=3 -> IDLE, no ready; a read of that word returns the old data.
//  - With MEM_RANGE_CHECK_EN and DEPTH_WORDS=256: write to 0x400 -> ready & err, RAM[0] unchanged; read of 0x400 -> 0xDEADBEEF. Without the macro, 0x400 aliases word 0.

Source files
------------

// File: rtl/mc_mem_pkg.sv
// Shared definitions for the multi-cycle CPU memory responder:
// FSM state encoding, the error word returned on out-of-range reads,
// and the default RAM geometry.
package mc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] MEM_ERR_WORD        = 32'hDEAD_BEEF;
    localparam int          DEPTH_WORDS_DEFAULT = 256;
    localparam int          IDX_W               = $clog2(DEPTH_WORDS_DEFAULT);

endpackage

// File: rtl/mc_mem_array.sv
// Word RAM behind the responder: synchronous write, registered read.
// The read register is cleared by reset; the storage itself is not.
module mc_mem_array
    import mc_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int IW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];
    logic [31:0] rdata_r;

    // Commit a write into storage when the controller enables it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
    end

    // Capture the addressed word into the read register on a read enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r <= 32'h0000_0000;
        end else if (re) begin
            rdata_r <= mem_r[idx];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/mc_mem_responder.sv
// Memory-side responder for the multi-cycle CPU's unified port.
// Accepts one read or write in IDLE, waits a configurable number of
// cycles, then pulses ready for one cycle. A simultaneous read and
// write is serviced as a write.
// Optional build macro: MEM_RANGE_CHECK_EN flags addresses with bits
// set above the word-index field (err with ready, write suppressed,
// read returns MEM_ERR_WORD). Without it the address wraps silently.
module mc_mem_responder
    import mc_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int RD_LATENCY  = 2,
    parameter int WR_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int IW      = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CW      = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_LATENCY - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_LATENCY - 1);

    state_t         state_r, state_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic           accept_s, done_s;
    logic           op_wr_r;
    logic [IW-1:0]  idx_r;
    logic [31:0]    wdata_r;
    logic           ready_r, busy_r;
    logic           we_s, re_s;
    logic [31:0]    arr_rdata_s;
    logic           oor_s, oor_r;

`ifdef MEM_RANGE_CHECK_EN
    logic           err_r;
    logic           rd_oor_r;
    logic           unused_addr_s;
    assign oor_s         = (addr[31:IW+2] != {(30-IW){1'b0}});
    assign unused_addr_s = ^addr[1:0];
`else
    logic           unused_addr_s;
    assign oor_s         = 1'b0;
    assign unused_addr_s = ^{addr[31:IW+2], addr[1:0]};
`endif

    // Next-state, latency countdown and accept/complete strobes.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_s  = BUSY;
                    accept_s = 1'b1;
                    cnt_s    = mem_write ? WR_LOAD : RD_LOAD;
                end else begin
                    state_s  = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = RESP;
                    done_s  = 1'b1;
                end else begin
                    cnt_s   = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counter and the registered ready/busy outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= (state_s == RESP);
            busy_r  <= (state_s != IDLE);
        end
    end

    // Latch the request at the accept edge; later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_wr_r <= 1'b0;
            idx_r   <= {IW{1'b0}};
            wdata_r <= 32'h0000_0000;
            oor_r   <= 1'b0;
        end else if (accept_s) begin
            op_wr_r <= mem_write;
            idx_r   <= addr[IW+1:2];
            wdata_r <= wdata;
            oor_r   <= oor_s;
        end
    end

    // The RAM access happens on the final BUSY edge so RESP sees the result.
    assign we_s = done_s & op_wr_r & ~oor_r;
    assign re_s = done_s & ~op_wr_r;

    mc_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IW          (IW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (we_s),
        .re    (re_s),
        .idx   (idx_r),
        .wdata (wdata_r),
        .rdata (arr_rdata_s)
    );

`ifdef MEM_RANGE_CHECK_EN
    // Error pulse aligned with ready, and the out-of-range flag of the last read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r    <= 1'b0;
            rd_oor_r <= 1'b0;
        end else begin
            err_r    <= done_s & oor_r;
            if (re_s) begin
                rd_oor_r <= oor_r;
            end
        end
    end

    assign err   = err_r;
    assign rdata = rd_oor_r ? MEM_ERR_WORD : arr_rdata_s;
`else
    assign err   = 1'b0;
    assign rdata = arr_rdata_s;
`endif

    assign ready = ready_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_mc_mem_responder.sv
// Scoreboard bench for mc_mem_responder: the driver pushes the expected
// response of each accepted request, the monitor pops on every ready.
// Follows MEM_RANGE_CHECK_EN in the same way as the design.
module tb_mc_mem_responder;

    localparam int DEPTH = 256;
    localparam int RDL   = 2;
    localparam int WRL   = 1;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ready, busy, err;

    mc_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .RD_LATENCY  (RDL),
        .WR_LATENCY  (WRL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          is_rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [DEPTH];
    logic [31:0] last_rd = 32'h0;
    int          checks = 0;
    int          errors = 0;

`ifdef MEM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    // Monitor: compare each ready pulse with the oldest expectation, and
    // check that rdata holds and err stays low between pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready cyc=%0d actual ready=1 required none pending", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (cyc != e.due || err != e.err || (e.is_rd && rdata != e.data)) begin
                        errors++;
                        $display("FAIL response cyc=%0d actual(cyc=%0d err=%0b rdata=%h) required(cyc=%0d err=%0b rdata=%h rd=%0b)",
                                 cyc, cyc, err, rdata, e.due, e.err, e.data, e.is_rd);
                    end
                    if (e.is_rd) last_rd = e.data;
                end
            end else begin
                checks++;
                if (rdata != last_rd || err != 1'b0) begin
                    errors++;
                    $display("FAIL hold cyc=%0d actual(rdata=%h err=%0b) required(rdata=%h err=0)",
                             cyc, rdata, err, last_rd);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Issue one request, push its expected response, wait (bounded) for ready.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble);
        int          lat;
        bit          oor;
        int          idx;
        exp_t        e;
        bit          seen;
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        @(negedge clk);
        idx = int'(a[9:2]);
        oor = RANGE_EN && (a[31:10] != 22'd0);
        lat = wr ? WRL : RDL;
        e.due = cyc + lat;
        e.is_rd = !wr;
        e.err = oor;
        e.data = 32'h0;
        if (wr) begin
            if (!oor) mem_m[idx] = d;
        end else begin
            e.data = oor ? ERR_WORD : mem_m[idx];
        end
        sb.push_back(e);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ready) begin
                seen = 1'b1;
                break;
            end
            if (scramble) begin
                addr = $urandom; wdata = $urandom;
                mem_read = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        mem_read = 1'b0; mem_write = 1'b0;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL ready_timeout addr=%h actual no ready required ready within 20 cycles", a);
        end
        @(negedge clk);
        check("idle_after_resp", {30'd0, busy, ready}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0;
        sb.delete();
        last_rd = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        bit          rd, wr;
        do_reset();
        check("reset_outputs", {rdata[28:0], ready, busy, err}, 32'd0);
        check("reset_rdata", rdata, 32'h0);

        // Directed scenarios.
        access(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        access(1'b1, 1'b1, 32'h20, 32'h0000_1234, 1'b0);
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        access(1'b0, 1'b1, 32'h30, 32'h1111_2222, 1'b1);
        access(1'b1, 1'b0, 32'h30, 32'h0, 1'b1);

        // Give words 0..15 known contents.
        for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

        // Address above the index field: error or alias to word 0.
        access(1'b0, 1'b1, 32'h400, 32'h0000_55AA, 1'b0);
        access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        access(1'b1, 1'b0, 32'h400, 32'h0, 1'b0);

        // Randomised traffic over the initialised words.
        for (int n = 0; n < 60; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 2) == 0);
            if (!rd && !wr) rd = 1'b1;
            a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = a | ($urandom & 32'hFFFF_FC00) | 32'h400;
            d = $urandom;
            access(rd, wr, a, d, 1'($urandom_range(0, 1)));
        end

        // Reset right after accepting a write: no ready, old data kept.
        @(negedge clk);
        mem_write = 1'b1; addr = 32'h14; wdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        mem_write = 1'b0;
        sb.delete();
        last_rd = 32'h0;
        @(negedge clk);
        check("reset_mid_op", {rdata[28:0], ready, busy, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        access(1'b1, 1'b0, 32'h14, 32'h0, 1'b0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
